// File: rtl/mmu_req_dispatcher_pkg.sv
// Shared MMU request definitions: field widths, fail reasons, page count and dispatcher FSM encodings.
package mmu_req_dispatcher_pkg;
  localparam int ID_W        = 13;
  localparam int SIZE_W      = 4;
  localparam int PIDX_W      = 15;
  localparam int FR_W        = 2;
  localparam int TOTAL_PAGES = 3276;

  localparam logic [FR_W-1:0] FAIL_NONE  = 2'd0;
  localparam logic [FR_W-1:0] FAIL_SIZE  = 2'd1;
  localparam logic [FR_W-1:0] FAIL_RANGE = 2'd2;
  localparam logic [FR_W-1:0] FAIL_ALIGN = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE, ST_REJECT} state_e;
  typedef enum logic {SRC_ALLOC = 1'b0, SRC_FREE = 1'b1} src_e;

  typedef struct packed {
    logic              is_free;
    logic [ID_W-1:0]   id;
    logic [PIDX_W-1:0] idx;
    logic [1:0]        order;
    logic [FR_W-1:0]   reason;
  } req_t;
endpackage

// File: rtl/mmu_req_dispatcher_if.sv
// Request FIFO, core handshake and response FIFO signals around the dispatcher.
interface mmu_req_dispatcher_if;
  import mmu_req_dispatcher_pkg::*;

  logic              alloc_fifo_empty;
  logic              alloc_req_pop;
  logic [ID_W-1:0]   alloc_req_id;
  logic [SIZE_W-1:0] alloc_req_page_count;
  logic              free_fifo_empty;
  logic              free_req_pop;
  logic [ID_W-1:0]   free_req_id;
  logic [PIDX_W-1:0] free_req_page_idx;
  logic [SIZE_W-1:0] free_req_page_count;
  logic              core_valid;
  logic              core_ready;
  logic              core_is_free;
  logic [ID_W-1:0]   core_id;
  logic [PIDX_W-1:0] core_page_idx;
  logic [1:0]        core_order;
  logic              alloc_rsp_fifo_full;
  logic              alloc_rsp_write_en;
  logic [ID_W-1:0]   alloc_rsp_id;
  logic [PIDX_W-1:0] alloc_rsp_page_idx;
  logic              alloc_rsp_fail;
  logic [FR_W-1:0]   alloc_rsp_fail_reason;
  logic              free_rsp_fifo_full;
  logic              free_rsp_write_en;
  logic [ID_W-1:0]   free_rsp_id;
  logic              free_rsp_fail;
  logic [FR_W-1:0]   free_rsp_fail_reason;

  modport master (
    input  alloc_fifo_empty, alloc_req_id, alloc_req_page_count,
           free_fifo_empty, free_req_id, free_req_page_idx, free_req_page_count,
           core_ready, alloc_rsp_fifo_full, free_rsp_fifo_full,
    output alloc_req_pop, free_req_pop,
           core_valid, core_is_free, core_id, core_page_idx, core_order,
           alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
           free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason
  );

  modport slave (
    output alloc_fifo_empty, alloc_req_id, alloc_req_page_count,
           free_fifo_empty, free_req_id, free_req_page_idx, free_req_page_count,
           core_ready, alloc_rsp_fifo_full, free_rsp_fifo_full,
    input  alloc_req_pop, free_req_pop,
           core_valid, core_is_free, core_id, core_page_idx, core_order,
           alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
           free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason
  );
endinterface

// File: rtl/mmu_req_check.sv
// Combinational page-count normalisation and request validation; shared with the core's free path.
module mmu_req_check
  import mmu_req_dispatcher_pkg::*;
(
  input  logic              is_free,
  input  logic [SIZE_W-1:0] count,
  input  logic [PIDX_W-1:0] idx,
  output logic [1:0]        order,
  output logic              fail,
  output logic [FR_W-1:0]   reason
);
  localparam int XW = PIDX_W + 1;

  // One extra bit so idx + pages cannot wrap near the top of the index space.
  logic [XW-1:0] idx_x, npages, end_x;
  logic          size_ok;

  always_comb begin
    order   = 2'd0;
    size_ok = 1'b1;
    case (count)
      SIZE_W'(1):                                     order = 2'd0;
      SIZE_W'(2):                                     order = 2'd1;
      SIZE_W'(3), SIZE_W'(4):                         order = 2'd2;
      SIZE_W'(5), SIZE_W'(6), SIZE_W'(7), SIZE_W'(8): order = 2'd3;
      default:                                        size_ok = 1'b0;
    endcase

    idx_x  = {1'b0, idx};
    npages = XW'(1) << order;
    end_x  = idx_x + npages;

    reason = FAIL_NONE;
    if (!size_ok)                                reason = FAIL_SIZE;
    else if (is_free) begin
      if (idx_x >= XW'(TOTAL_PAGES))             reason = FAIL_RANGE;
      else if ((idx_x & (npages - XW'(1))) != '0) reason = FAIL_ALIGN;
      else if (end_x > XW'(TOTAL_PAGES))         reason = FAIL_RANGE;
    end
    fail = (reason != FAIL_NONE);
  end
endmodule

// File: rtl/mmu_req_dispatcher.sv
// Round-robin pops alloc/free request FIFOs, validates, then issues to the core or rejects to the rsp FIFO.
// Define MMU_DISPATCH_STATS_EN to add saturating stat_issued/stat_rejected counters.
module mmu_req_dispatcher
  import mmu_req_dispatcher_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mmu_req_dispatcher_if.master bus
`ifdef MMU_DISPATCH_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_rejected
`endif
);
  state_e            state_q, state_d;
  src_e              rr_last_q, src_q, pick;
  req_t              cur_q;
  logic              alloc_rdy, free_rdy, any_rdy, rsp_full;
  logic              chk_is_free, chk_fail;
  logic [SIZE_W-1:0] chk_count;
  logic [PIDX_W-1:0] chk_idx;
  logic [1:0]        chk_order;
  logic [FR_W-1:0]   chk_reason;

  assign alloc_rdy = !bus.alloc_fifo_empty;
  assign free_rdy  = !bus.free_fifo_empty;
  assign any_rdy   = alloc_rdy || free_rdy;
  assign pick      = (free_rdy && (!alloc_rdy || rr_last_q == SRC_ALLOC)) ? SRC_FREE : SRC_ALLOC;
  assign rsp_full  = (src_q == SRC_FREE) ? bus.free_rsp_fifo_full : bus.alloc_rsp_fifo_full;

  // FIFO read data is only meaningful in WAIT, which is the only state that captures it.
  assign chk_is_free = (src_q == SRC_FREE);
  assign chk_count   = chk_is_free ? bus.free_req_page_count : bus.alloc_req_page_count;
  assign chk_idx     = chk_is_free ? bus.free_req_page_idx : '0;

  mmu_req_check u_check (
    .is_free (chk_is_free),
    .count   (chk_count),
    .idx     (chk_idx),
    .order   (chk_order),
    .fail    (chk_fail),
    .reason  (chk_reason)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_rdy)        state_d = ST_WAIT;
      ST_WAIT:                       state_d = chk_fail ? ST_REJECT : ST_ISSUE;
      ST_ISSUE:  if (bus.core_ready) state_d = ST_IDLE;
      ST_REJECT: if (!rsp_full)      state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.alloc_req_pop      = 1'b0;
    bus.free_req_pop       = 1'b0;
    bus.core_valid         = 1'b0;
    bus.alloc_rsp_write_en = 1'b0;
    bus.free_rsp_write_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.alloc_req_pop = any_rdy && (pick == SRC_ALLOC);
        bus.free_req_pop  = any_rdy && (pick == SRC_FREE);
      end
      ST_ISSUE: bus.core_valid = 1'b1;
      ST_REJECT: begin
        bus.alloc_rsp_write_en = !rsp_full && (src_q == SRC_ALLOC);
        bus.free_rsp_write_en  = !rsp_full && (src_q == SRC_FREE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= SRC_FREE;
      src_q     <= SRC_ALLOC;
      cur_q     <= '0;
    end else begin
      if (state_q == ST_IDLE && any_rdy) begin
        src_q     <= pick;
        rr_last_q <= pick;
      end
      if (state_q == ST_WAIT) begin
        cur_q.is_free <= chk_is_free;
        cur_q.id      <= chk_is_free ? bus.free_req_id : bus.alloc_req_id;
        cur_q.idx     <= chk_idx;
        cur_q.order   <= chk_order;
        cur_q.reason  <= chk_reason;
      end
    end
  end

  assign bus.core_is_free          = cur_q.is_free;
  assign bus.core_id               = cur_q.id;
  assign bus.core_page_idx         = cur_q.idx;
  assign bus.core_order            = cur_q.order;
  assign bus.alloc_rsp_id          = cur_q.id;
  assign bus.alloc_rsp_page_idx    = '0;
  assign bus.alloc_rsp_fail        = bus.alloc_rsp_write_en;
  assign bus.alloc_rsp_fail_reason = cur_q.reason;
  assign bus.free_rsp_id           = cur_q.id;
  assign bus.free_rsp_fail         = bus.free_rsp_write_en;
  assign bus.free_rsp_fail_reason  = cur_q.reason;

`ifdef MMU_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued   <= '0;
      stat_rejected <= '0;
    end else begin
      if (bus.core_valid && bus.core_ready && stat_issued != '1)
        stat_issued <= stat_issued + 32'd1;
      if ((bus.alloc_rsp_write_en || bus.free_rsp_write_en) && stat_rejected != '1)
        stat_rejected <= stat_rejected + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mmu_req_dispatcher.sv
// Bench for mmu_req_dispatcher: FIFO models, scoreboard against a page-arithmetic reference, vector table, corner sequences, random traffic.
module tb_mmu_req_dispatcher;
  import mmu_req_dispatcher_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmu_req_dispatcher_if bus();
`ifdef MMU_DISPATCH_STATS_EN
  logic [31:0] stat_issued, stat_rejected;
`endif

  mmu_req_dispatcher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MMU_DISPATCH_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_rejected (stat_rejected)
`endif
  );

  typedef struct { int id; int idx; int cnt; } tb_req_t;
  typedef struct { bit is_free; int id; int idx; int order; int reason; int pop_cyc; } exp_t;
  typedef struct { bit is_free; int id; int idx; int cnt; bit issue; int order; int reason; } vec_t;

  tb_req_t aq[$], fq[$];
  exp_t    expq[$];
  bit      pop_log[$];
  int      a_wr = 0, a_rd = 0, f_wr = 0, f_rd = 0;
  int      cyc = 0, n_chk = 0, n_fail = 0;
  logic    core_ready_r = 1'b0, a_full = 1'b0, f_full = 1'b0;
  bit      m_last = 1'b1;
  int      ev_cnt = 0, ev_id, ev_idx, ev_order, ev_reason, ev_lat, n_iss = 0, n_rej = 0;
  bit      ev_issue, ev_is_free;

  assign bus.alloc_fifo_empty    = (a_rd == a_wr);
  assign bus.free_fifo_empty     = (f_rd == f_wr);
  assign bus.core_ready          = core_ready_r;
  assign bus.alloc_rsp_fifo_full = a_full;
  assign bus.free_rsp_fifo_full  = f_full;

  always @(posedge clk) cyc <= cyc + 1;

  // Request FIFOs: read data appears the cycle after the pop.
  always @(posedge clk) begin
    if (bus.alloc_req_pop && a_rd < a_wr) begin
      bus.alloc_req_id         <= ID_W'(aq[a_rd].id);
      bus.alloc_req_page_count <= SIZE_W'(aq[a_rd].cnt);
      a_rd                     <= a_rd + 1;
    end
    if (bus.free_req_pop && f_rd < f_wr) begin
      bus.free_req_id          <= ID_W'(fq[f_rd].id);
      bus.free_req_page_idx    <= PIDX_W'(fq[f_rd].idx);
      bus.free_req_page_count  <= SIZE_W'(fq[f_rd].cnt);
      f_rd                     <= f_rd + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: smallest power-of-two block covering cnt, then free-range/alignment rules.
  function automatic void model(input bit is_free, input int cnt, input int idx,
                                output int order, output int reason);
    int pages;
    order = 0; reason = 0;
    if (cnt < 1 || cnt > 8) begin reason = 1; return; end
    pages = 1;
    while (pages < cnt) begin pages = pages * 2; order++; end
    if (is_free) begin
      if (idx >= TOTAL_PAGES)              reason = 2;
      else if (idx % pages != 0)           reason = 3;
      else if (idx + pages > TOTAL_PAGES)  reason = 2;
    end
  endfunction

  task automatic push_alloc(input int id, input int cnt);
    tb_req_t r;
    r.id = id; r.idx = 0; r.cnt = cnt;
    aq.push_back(r); a_wr++;
  endtask

  task automatic push_free(input int id, input int idx, input int cnt);
    tb_req_t r;
    r.id = id; r.idx = idx; r.cnt = cnt;
    fq.push_back(r); f_wr++;
  endtask

  task automatic wait_ev(input int target, input int budget, input string name);
    int k = 0;
    while (ev_cnt < target && k < budget) begin @(posedge clk); k++; end
    chk(name, ev_cnt >= target, 1);
  endtask

  task automatic wait_pop(input int target, input int budget, input string name);
    int k = 0;
    while (pop_log.size() < target && k < budget) begin @(posedge clk); k++; end
    chk(name, pop_log.size() >= target, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pop_log.delete();
  endtask

  // Scoreboard: arbitration order, one-in-flight, and every issue/reject against the reference.
  always @(negedge clk) begin
    exp_t    e;
    tb_req_t r;
    bit a_ne, f_ne, want_free, hs, wr;
    if (!rst_n) begin
      expq.delete(); m_last = 1'b1; n_iss = 0; n_rej = 0;
    end else begin
      if (bus.alloc_req_pop || bus.free_req_pop) begin
        a_ne = (a_rd != a_wr); f_ne = (f_rd != f_wr);
        want_free = f_ne && (!a_ne || !m_last);
        chk("pop_one_hot", bus.alloc_req_pop && bus.free_req_pop, 0);
        chk("pop_source", bus.free_req_pop, want_free);
        chk("pop_in_flight", expq.size(), 0);
        m_last = bus.free_req_pop;
        pop_log.push_back(bus.free_req_pop);
        if (bus.free_req_pop ? f_ne : a_ne) begin
          r = bus.free_req_pop ? fq[f_rd] : aq[a_rd];
          e.is_free = bus.free_req_pop;
          e.id      = r.id;
          e.idx     = e.is_free ? r.idx : 0;
          model(e.is_free, r.cnt, r.idx, e.order, e.reason);
          e.pop_cyc = cyc;
          expq.push_back(e);
        end
      end
      hs = bus.core_valid && bus.core_ready;
      wr = bus.alloc_rsp_write_en || bus.free_rsp_write_en;
      if (hs || wr) begin
        chk("one_event", hs && wr, 0);
        chk("event_expected", expq.size() != 0, 1);
        ev_issue = hs;
        if (hs) begin
          ev_is_free = bus.core_is_free; ev_id = int'(bus.core_id);
          ev_order = int'(bus.core_order); ev_idx = int'(bus.core_page_idx);
          ev_reason = 0; n_iss++;
        end else if (bus.free_rsp_write_en) begin
          ev_is_free = 1'b1; ev_id = int'(bus.free_rsp_id);
          ev_reason = int'(bus.free_rsp_fail_reason); n_rej++;
          chk("free_rsp_fail", bus.free_rsp_fail, 1);
          chk("rsp_both_wen", bus.alloc_rsp_write_en, 0);
        end else begin
          ev_is_free = 1'b0; ev_id = int'(bus.alloc_rsp_id);
          ev_reason = int'(bus.alloc_rsp_fail_reason); n_rej++;
          chk("alloc_rsp_fail", bus.alloc_rsp_fail, 1);
          chk("alloc_rsp_page_idx", bus.alloc_rsp_page_idx, 0);
        end
        if (expq.size() != 0) begin
          e = expq.pop_front();
          ev_lat = cyc - e.pop_cyc;
          chk("ev_is_free", ev_is_free, e.is_free);
          chk("ev_id", ev_id, e.id);
          chk("ev_reason", ev_reason, e.reason);
          if (hs) begin
            chk("ev_order", ev_order, e.order);
            chk("ev_idx", ev_idx, e.idx);
          end
          chk("ev_latency_min", ev_lat >= 2, 1);
        end
        ev_cnt++;
      end
    end
  end

  vec_t tv[16];

  initial begin
    int n0, np, k;
    bit fr;
    tv[0]  = '{0, 5,    0,    3, 1, 2, 0};
    tv[1]  = '{1, 6,    8,    8, 1, 3, 0};
    tv[2]  = '{1, 7,    6,    4, 0, 0, 3};
    tv[3]  = '{0, 8,    0,    0, 0, 0, 1};
    tv[4]  = '{0, 9,    0,    9, 0, 0, 1};
    tv[5]  = '{1, 10,   3276, 1, 0, 0, 2};
    tv[6]  = '{1, 11,   3272, 8, 0, 0, 2};
    tv[7]  = '{1, 12,   3264, 8, 1, 3, 0};
    tv[8]  = '{1, 13,   3275, 1, 1, 0, 0};
    tv[9]  = '{1, 14,   3272, 4, 1, 2, 0};
    tv[10] = '{0, 15,   0,    5, 1, 3, 0};
    tv[11] = '{1, 16,   3,    2, 0, 0, 3};
    tv[12] = '{1, 17,   0,    0, 0, 0, 1};
    tv[13] = '{1, 18,   4001, 3, 0, 0, 2};
    tv[14] = '{0, 8191, 0,    8, 1, 3, 0};
    tv[15] = '{1, 1,    3274, 2, 1, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_valid", bus.core_valid, 0);
    chk("rst_core_id", bus.core_id, 0);
    chk("rst_core_order", bus.core_order, 0);
    chk("rst_alloc_pop", bus.alloc_req_pop, 0);
    chk("rst_free_pop", bus.free_req_pop, 0);
    chk("rst_alloc_wen", bus.alloc_rsp_write_en, 0);
    chk("rst_free_wen", bus.free_rsp_write_en, 0);
    rst_n = 1'b1;
    core_ready_r = 1'b1;

    // Vector table, one request at a time
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      n0 = ev_cnt;
      if (tv[i].is_free) push_free(tv[i].id, tv[i].idx, tv[i].cnt);
      else               push_alloc(tv[i].id, tv[i].cnt);
      wait_ev(n0 + 1, 20, "vec_timeout");
      chk("vec_issue", ev_issue, tv[i].issue);
      chk("vec_is_free", ev_is_free, tv[i].is_free);
      chk("vec_id", ev_id, tv[i].id);
      chk("vec_reason", ev_reason, tv[i].reason);
      if (tv[i].issue) chk("vec_order", ev_order, tv[i].order);
      chk("vec_latency", ev_lat, 2);
    end

    // Both FIFOs loaded after reset: strict alternation starting with alloc
    do_reset();
    #1;
    n0 = ev_cnt;
    for (int i = 0; i < 3; i++) begin
      push_alloc(100 + i, 1);
      push_free(200 + i, 8 * i, 1);
    end
    wait_ev(n0 + 6, 60, "alt_timeout");
    chk("alt_pop_count", pop_log.size(), 6);
    for (int i = 0; i < 6 && i < pop_log.size(); i++) chk("alt_pop_src", pop_log[i], i % 2);

    // Reject held while the free response FIFO is full
    @(posedge clk); #1;
    f_full = 1'b1;
    k = pop_log.size();
    n0 = ev_cnt;
    push_free(77, 6, 4);
    wait_pop(k + 1, 10, "hold_pop_timeout");
    @(posedge clk); #1;
    push_alloc(78, 2);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("hold_no_wen", bus.free_rsp_write_en, 0);
      chk("hold_no_pop", bus.alloc_req_pop || bus.free_req_pop, 0);
      @(posedge clk); #1;
    end
    f_full = 1'b0;
    #1;
    chk("hold_wen", bus.free_rsp_write_en, 1);
    chk("hold_reason", bus.free_rsp_fail_reason, 3);
    chk("hold_id", bus.free_rsp_id, 77);
    wait_ev(n0 + 2, 20, "hold_drain_timeout");
    chk("hold_after_issue_id", ev_id, 78);

    // Reset while a request waits on core_ready
    @(posedge clk); #1;
    core_ready_r = 1'b0;
    k = pop_log.size();
    push_alloc(300, 2);
    wait_pop(k + 1, 10, "mid_pop_timeout");
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_core_valid", bus.core_valid, 0);
    chk("mid_rst_core_id", bus.core_id, 0);
    chk("mid_rst_core_order", bus.core_order, 0);
    chk("mid_rst_pops", bus.alloc_req_pop || bus.free_req_pop, 0);
    chk("mid_rst_wens", bus.alloc_rsp_write_en || bus.free_rsp_write_en, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pop_log.delete();
    repeat (3) @(posedge clk);
    #1;
    core_ready_r = 1'b1;
    n0 = ev_cnt;
    push_free(401, 16, 2);
    push_alloc(400, 1);
    wait_ev(n0 + 2, 30, "mid_after_timeout");
    chk("mid_first_pop_alloc", pop_log.size() > 0 && pop_log[0] == 1'b0, 1);
    chk("mid_no_stale_event", ev_cnt - n0, 2);

    // Random traffic against the reference scoreboard
    n0 = ev_cnt;
    np = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      core_ready_r = ($urandom_range(0, 3) != 0);
      a_full = ($urandom_range(0, 3) == 0);
      f_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        int cnt, idx, id;
        fr  = $urandom_range(0, 1);
        cnt = $urandom_range(0, 10);
        id  = $urandom_range(0, 8191);
        case ($urandom_range(0, 3))
          0:       idx = $urandom_range(0, TOTAL_PAGES + 20);
          1:       idx = TOTAL_PAGES - $urandom_range(0, 16);
          2:       idx = $urandom_range(0, 409) * 8;
          default: idx = $urandom_range(0, 32767);
        endcase
        if (fr) push_free(id, idx, cnt);
        else    push_alloc(id, cnt);
        np++;
      end
    end
    core_ready_r = 1'b1; a_full = 1'b0; f_full = 1'b0;
    wait_ev(n0 + np, 2000, "rand_drain_timeout");
    chk("rand_event_count", ev_cnt - n0, np);
    chk("rand_queues_empty", (a_rd == a_wr) && (f_rd == f_wr), 1);

`ifdef MMU_DISPATCH_STATS_EN
    #1;
    chk("stat_issued", stat_issued, n_iss);
    chk("stat_rejected", stat_rejected, n_rej);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
